// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-cycle ROM latency, branch squash and a small return stack.
// Optional FETCH_STACK4_EN widens the return stack from 2 to 4 entries.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jmp,
  input  logic        call,
  input  logic        ret,
  input  logic        skip,
  input  logic [10:0] jmp_addr,
  output logic [10:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] ir,
  output logic        ir_valid,
  output logic [10:0] ir_pc,
  output logic        stk_ovf,
  output logic        stk_unf
);

`ifdef FETCH_STACK4_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 2;
`endif
  localparam int DW = $clog2(DEPTH + 1);

  logic [10:0]   pc_f;
  logic [10:0]   stk [DEPTH];
  logic [DW-1:0] depth;
  logic          primed;
  logic [10:0]   stk_top;
  logic          squash;
  logic          push;
  logic          pop;

  // An empty stack still presents its bottom entry, which is what an underflowing ret returns.
  always_comb begin
    stk_top = stk[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (depth == DW'(i + 1)) stk_top = stk[i];
    end
  end

  assign squash = !stall && (jmp || call || ret || skip);
  assign pop    = !stall && ret;
  assign push   = !stall && !ret && call;

  always_comb begin
    if (rst)                rom_addr = 11'h7FF;
    else if (stall)         rom_addr = pc_f;
    else if (ret)           rom_addr = stk_top;
    else if (call || jmp)   rom_addr = jmp_addr;
    else                    rom_addr = pc_f + 11'd1;
  end

  // primed masks the word latched on the first cycle after reset, whose ROM address predates pc_f.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f     <= 11'h7FE;
      ir       <= 12'h000;
      ir_valid <= 1'b0;
      ir_pc    <= 11'h000;
      primed   <= 1'b0;
    end else if (!stall) begin
      pc_f   <= rom_addr;
      ir_pc  <= pc_f;
      primed <= 1'b1;
      if (squash) begin
        ir       <= 12'h000;
        ir_valid <= 1'b0;
      end else begin
        ir       <= rom_data;
        ir_valid <= primed;
      end
    end
  end

  // A push into a full stack shifts the oldest entry out of the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= 11'h000;
      depth   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (push) begin
      if (depth == DW'(DEPTH)) begin
        for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
        stk[DEPTH-1] <= pc_f;
        stk_ovf      <= 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (depth == DW'(i)) stk[i] <= pc_f;
        end
        depth <= depth + DW'(1);
      end
    end else if (pop) begin
      if (depth == '0) stk_unf <= 1'b1;
      else             depth   <= depth - DW'(1);
    end
  end

endmodule
